// File: rtl/clz_seq.sv
// clz_seq: sequential count-leading-zeros / count-leading-ones unit (MIPS clz/clo).
// The operand is scanned CHUNK bits per cycle from the MSB behind a start/busy/done
// handshake. Leading-ones mode inverts the operand once at capture and reuses the
// leading-zeros datapath.
// Optional feature macro: CLZ_SEQ_EARLY_EXIT_EN. When defined, the scan stops on the
// first chunk holding a counted bit; otherwise every operation takes WIDTH/CHUNK cycles
// and the count freezes once the first counted bit has been seen.
module clz_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int RW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    result
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [RW-1:0] CHUNK_W  = RW'(CHUNK);
    localparam logic [RW-1:0] ONE_W    = RW'(32'd1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] sreg_r, sreg_nxt_s;
    logic [RW-1:0]    cnt_r, cnt_nxt_s;
    logic [RW-1:0]    result_r, result_nxt_s;
    logic [IW-1:0]    idx_r, idx_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
`ifdef CLZ_SEQ_EARLY_EXIT_EN
`else
    logic             found_r, found_nxt_s;
`endif

    logic [CHUNK-1:0] top_s;
    logic             any_s;
    logic             last_s;
    logic [RW-1:0]    step_s;

    // Number of zeros above the first set bit of one chunk (CHUNK when the chunk is empty).
    function automatic logic [RW-1:0] chunk_lz(input logic [CHUNK-1:0] c);
        logic [RW-1:0] n;
        logic          hit;
        n   = {RW{1'b0}};
        hit = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (hit) begin
                hit = 1'b1;
            end else if (c[i]) begin
                hit = 1'b1;
            end else begin
                n = n + ONE_W;
            end
        end
        return n;
    endfunction

    assign top_s  = sreg_r[WIDTH-1 -: CHUNK];
    assign any_s  = |top_s;
    assign last_s = (idx_r == LAST_IDX);
    // Running count after the current chunk: stop inside it if it holds a counted bit.
    assign step_s = any_s ? (cnt_r + chunk_lz(top_s)) : (cnt_r + CHUNK_W);

    // Next-state and datapath update for the IDLE/SCAN controller.
    always_comb begin
        state_nxt_s  = state_r;
        sreg_nxt_s   = sreg_r;
        cnt_nxt_s    = cnt_r;
        idx_nxt_s    = idx_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        result_nxt_s = result_r;
`ifdef CLZ_SEQ_EARLY_EXIT_EN
`else
        found_nxt_s  = found_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    sreg_nxt_s  = mode ? ~a : a;
                    cnt_nxt_s   = {RW{1'b0}};
                    idx_nxt_s   = {IW{1'b0}};
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = SCAN;
`ifdef CLZ_SEQ_EARLY_EXIT_EN
`else
                    found_nxt_s = 1'b0;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
`ifdef CLZ_SEQ_EARLY_EXIT_EN
                if (any_s) begin
                    result_nxt_s = step_s;
                    done_nxt_s   = 1'b1;
                    busy_nxt_s   = 1'b0;
                    state_nxt_s  = IDLE;
                end else begin
                    cnt_nxt_s  = step_s;
                    sreg_nxt_s = sreg_r << CHUNK;
                    idx_nxt_s  = idx_r + IDX_ONE;
                    if (last_s) begin
                        result_nxt_s = step_s;
                        done_nxt_s   = 1'b1;
                        busy_nxt_s   = 1'b0;
                        state_nxt_s  = IDLE;
                    end else begin
                        state_nxt_s = SCAN;
                    end
                end
`else
                sreg_nxt_s = sreg_r << CHUNK;
                idx_nxt_s  = idx_r + IDX_ONE;
                if (found_r) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s   = step_s;
                    found_nxt_s = any_s;
                end
                if (last_s) begin
                    result_nxt_s = found_r ? cnt_r : step_s;
                    done_nxt_s   = 1'b1;
                    busy_nxt_s   = 1'b0;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s = SCAN;
                end
`endif
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            sreg_r   <= {WIDTH{1'b0}};
            cnt_r    <= {RW{1'b0}};
            idx_r    <= {IW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {RW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            sreg_r   <= sreg_nxt_s;
            cnt_r    <= cnt_nxt_s;
            idx_r    <= idx_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            result_r <= result_nxt_s;
        end
    end

`ifdef CLZ_SEQ_EARLY_EXIT_EN
`else
    // Remembers that the counted bit was already seen so later chunks do not add to cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_r <= 1'b0;
        end else begin
            found_r <= found_nxt_s;
        end
    end
`endif

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_clz_seq.sv
// Testbench for clz_seq: three instances (32/4, 16/1, 64/8) share one clock and reset.
// Expected counts and latencies come from a bitwise reference model, queued at start
// and popped when done is observed.
module tb_clz_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start, mode;
    logic [31:0] a;
    logic        busy, done;
    logic [5:0]  result;

    logic        start16, mode16;
    logic [15:0] a16;
    logic        busy16, done16;
    logic [4:0]  result16;

    logic        start64, mode64;
    logic [63:0] a64;
    logic        busy64, done64;
    logic [6:0]  result64;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int res;
        int n;
    } exp_t;
    exp_t exp_q[$];

    clz_seq #(.WIDTH(32), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a),
        .busy(busy), .done(done), .result(result)
    );
    clz_seq #(.WIDTH(16), .CHUNK(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16),
        .busy(busy16), .done(done16), .result(result16)
    );
    clz_seq #(.WIDTH(64), .CHUNK(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .mode(mode64), .a(a64),
        .busy(busy64), .done(done64), .result(result64)
    );

    always #5 clk = ~clk;

    function automatic int width_of(input int which);
        case (which)
            1:       return 16;
            2:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int chunk_of(input int which);
        case (which)
            1:       return 1;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    // Reference: count leading bits equal to m, one bit at a time.
    function automatic int ref_count(input logic [63:0] v, input int w, input logic m);
        int n;
        n = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i] !== m) break;
            n++;
        end
        return n;
    endfunction

    function automatic int exp_n(input int r, input int w, input int c);
`ifdef CLZ_SEQ_EARLY_EXIT_EN
        if (r >= w) return w / c;
        return r / c + 1;
`else
        return w / c + (r - r);
`endif
    endfunction

    function automatic logic get_done(input int which);
        case (which)
            1:       return done16;
            2:       return done64;
            default: return done;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            1:       return busy16;
            2:       return busy64;
            default: return busy;
        endcase
    endfunction

    function automatic int get_res(input int which);
        case (which)
            1:       return int'(result16);
            2:       return int'(result64);
            default: return int'(result);
        endcase
    endfunction

    task automatic drive(input int which, input logic s, input logic [63:0] v, input logic m);
        case (which)
            1: begin start16 = s; a16 = v[15:0]; mode16 = m; end
            2: begin start64 = s; a64 = v;       mode64 = m; end
            default: begin start = s; a = v[31:0]; mode = m; end
        endcase
    endtask

    // Issue one operation, queue its expectation, and wait (bounded) for done.
    // Returns at the negedge inside the done cycle.
    task automatic do_op(input int which, input logic [63:0] v, input logic m,
                         input bit in_done_cycle,
                         output int obs_res, output int obs_n, output bit busy_ok);
        int w;
        int c;
        int r;
        exp_t e;
        w = width_of(which);
        c = chunk_of(which);
        if (!in_done_cycle) @(negedge clk);
        drive(which, 1'b1, v, m);
        r = ref_count(v, w, m);
        e.res = r;
        e.n   = exp_n(r, w, c);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        drive(which, 1'b0, v, m);
        busy_ok = (get_busy(which) === 1'b1) && (get_done(which) === 1'b0);
        obs_n   = 0;
        obs_res = -1;
        while (obs_n < 200) begin
            @(posedge clk);
            obs_n++;
            @(negedge clk);
            if (get_done(which) === 1'b1) begin
                obs_res = get_res(which);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 1'b0);
        drive(2, 1'b0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_tests++;
        if (result !== 6'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
        n_tests++;
        if ({busy16, done16, busy64, done64} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_sweep_duts got %b want 0000", {busy16, done16, busy64, done64});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb();
        int r, n;
        bit b;
        exp_t e;
        do_op(0, 64'h8000_0000, 1'b0, 1'b0, r, n, b);
        e = exp_q.pop_front();
        n_tests++;
        if (r !== e.res || r !== 0) begin n_fail++; $display("FAIL msb_result got %0d want %0d", r, e.res); end
        n_tests++;
        if (n !== e.n) begin n_fail++; $display("FAIL msb_latency got %0d want %0d", n, e.n); end
        n_tests++;
        if (!b) begin n_fail++; $display("FAIL msb_busy got 0 want 1"); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 6'd0) begin
            n_fail++;
            $display("FAIL msb_after_done got done=%0b busy=%0b result=%0d want 0 0 0", done, busy, result);
        end
    endtask

    task automatic test_runs();
        logic [31:0] va [5] = '{32'h0000_0001, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFF0_0000};
        logic        vm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int          vr [5] = '{31, 15, 32, 32, 12};
        int r, n;
        bit b;
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            do_op(0, {32'd0, va[k]}, vm[k], 1'b0, r, n, b);
            e = exp_q.pop_front();
            n_tests++;
            if (r !== e.res || r !== vr[k]) begin
                n_fail++;
                $display("FAIL run_result a=%h mode=%0b got %0d want %0d", va[k], vm[k], r, vr[k]);
            end
            n_tests++;
            if (n !== e.n) begin
                n_fail++;
                $display("FAIL run_latency a=%h got %0d want %0d", va[k], n, e.n);
            end
            n_tests++;
            if (!b) begin n_fail++; $display("FAIL run_busy a=%h got 0 want 1", va[k]); end
        end
    endtask

    task automatic test_handshake();
        int lat, gaps, r, n;
        bit b;
        exp_t e;
        // start held through SCAN with a different operand
        @(negedge clk);
        start = 1'b1; a = 32'h0001_0000; mode = 1'b0;
        e.res = ref_count(64'h0001_0000, 32, 1'b0);
        e.n   = exp_n(e.res, 32, 4);
        exp_q.push_back(e);
        @(posedge clk);
        lat = 0;
        gaps = 0;
        while (lat < 200) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (busy !== 1'b1) gaps++;
            a = 32'hFFFF_FFFF;
            mode = 1'b1;
            if (lat >= 1) start = 1'b0;
            @(posedge clk);
            lat++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if (int'(result) !== e.res || done !== 1'b1) begin
            n_fail++;
            $display("FAIL held_start_result got %0d done=%0b want %0d", result, done, e.res);
        end
        n_tests++;
        if (lat !== e.n) begin n_fail++; $display("FAIL held_start_latency got %0d want %0d", lat, e.n); end
        n_tests++;
        if (gaps !== 0) begin n_fail++; $display("FAIL held_start_busy got %0d gaps want 0", gaps); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start_requeue got done=%0b busy=%0b want 0 0", done, busy);
        end
        // start asserted in the done cycle
        do_op(0, 64'h0000_0000_0000_0100, 1'b0, 1'b0, r, n, b);
        e = exp_q.pop_front();
        n_tests++;
        if (r !== e.res) begin n_fail++; $display("FAIL b2b_first got %0d want %0d", r, e.res); end
        do_op(0, 64'h0000_0000_0800_0000, 1'b0, 1'b1, r, n, b);
        e = exp_q.pop_front();
        n_tests++;
        if (r !== e.res || r !== 4) begin n_fail++; $display("FAIL b2b_result got %0d want 4", r); end
        n_tests++;
        if (n !== e.n) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", n, e.n); end
        n_tests++;
        if (!b) begin n_fail++; $display("FAIL b2b_accept got busy=0 want 1"); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start = 1'b1; a = 32'h0000_0001; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%0b done=%0b result=%0d want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", seen); end
    endtask

    task automatic test_sweep(input int which);
        int w, c, r, n;
        bit b;
        logic [63:0] v, mask;
        logic m;
        exp_t e;
        w = width_of(which);
        c = chunk_of(which);
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        for (int k = 0; k < 20; k++) begin
            v = {$urandom(), $urandom()} & mask;
            v = v >> $urandom_range(0, w);
            m = 1'($urandom_range(0, 1));
            if (m) v = ~v & mask;
            do_op(which, v, m, 1'b0, r, n, b);
            e = exp_q.pop_front();
            n_tests++;
            if (r !== e.res) begin
                n_fail++;
                $display("FAIL sweep%0d_result v=%h mode=%0b got %0d want %0d", w, v, m, r, e.res);
            end
            n_tests++;
            if (n !== e.n || n < 1 || n > w / c) begin
                n_fail++;
                $display("FAIL sweep%0d_latency v=%h got %0d want %0d", w, v, n, e.n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb();
        test_runs();
        test_handshake();
        test_reset_mid();
        test_sweep(1);
        test_sweep(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
